// File: rtl/ps2_cmd_arbiter.sv
// ps2_cmd_arbiter: lets two command requesters share one PS/2 host transmitter.
// Each command byte is framed, sent once the transmitter is idle, and the device
// response (ACK FA / ERROR FC / RESEND FE) is awaited with retry and timeout.
// Build option: define PS2_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// left undefined, req0 has fixed priority over req1.
module ps2_cmd_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic        clk_25MHz,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  cmd0,
    input  logic [7:0]  cmd1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done,
    output logic        done_id,
    output logic [1:0]  done_err,
    output logic [10:0] tx_data,
    output logic        write,
    input  logic        busy,
    input  logic [10:0] rx_data,
    input  logic        data_available,
    input  logic        err
);

    localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
    localparam logic [RetryW-1:0] RetryMax  = RetryW'(MAX_RETRY);

    localparam logic [1:0] ErrOk      = 2'b00;
    localparam logic [1:0] ErrDevice  = 2'b01;
    localparam logic [1:0] ErrRetries = 2'b10;
    localparam logic [1:0] ErrTimeout = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StArbGnt,
        StWaitTx,
        StSend,
        StWaitRsp,
        StDone
    } state_e;

    state_e              state_q;
    logic                owner_q;
    logic [7:0]          cmd_q;
    logic [RetryW-1:0]   retry_q;
    logic [TimerW-1:0]   timer_q;
`ifdef PS2_ARB_ROUND_ROBIN_EN
    logic                last_owner_q;
`endif

    logic rsp_valid;
    logic rsp_ack;
    logic rsp_dev_err;
    logic pick;

    // Start/stop bits of the response are not checked; only data and parity matter.
    logic unused_rx_frame;
    assign unused_rx_frame = ^{rx_data[10], rx_data[0]};

    // Response classification and arbitration choice for the current cycle.
    always_comb begin
        rsp_valid   = data_available && !err && (rx_data[9] == ~^rx_data[8:1]);
        rsp_ack     = rsp_valid && (rx_data[8:1] == 8'hFA);
        rsp_dev_err = rsp_valid && (rx_data[8:1] == 8'hFC);
`ifdef PS2_ARB_ROUND_ROBIN_EN
        // On a tie the requester that did not own the previous transaction wins.
        pick = (req0 && req1) ? ~last_owner_q : !req0;
`else
        pick = !req0;
`endif
    end

    // Transaction FSM with registered handshake and transmitter outputs.
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            cmd_q        <= 8'h00;
            retry_q      <= '0;
            timer_q      <= '0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            done         <= 1'b0;
            done_id      <= 1'b0;
            done_err     <= ErrOk;
            tx_data      <= 11'h7FF;
            write        <= 1'b0;
`ifdef PS2_ARB_ROUND_ROBIN_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            write <= 1'b0;
            done  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req0 || req1) begin
                        owner_q <= pick;
                        cmd_q   <= pick ? cmd1 : cmd0;
                        gnt0    <= !pick;
                        gnt1    <= pick;
`ifdef PS2_ARB_ROUND_ROBIN_EN
                        last_owner_q <= pick;
`endif
                        state_q <= StArbGnt;
                    end
                end
                StArbGnt: begin
                    tx_data <= {1'b1, ~^cmd_q, cmd_q, 1'b0};
                    state_q <= StWaitTx;
                end
                StWaitTx: begin
                    if (!busy) begin
                        write   <= 1'b1;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    timer_q <= '0;
                    state_q <= StWaitRsp;
                end
                StWaitRsp: begin
                    // Any strobe is resolved here, so it takes precedence over a
                    // timer expiring in the same cycle.
                    if (data_available) begin
                        if (rsp_ack) begin
                            done     <= 1'b1;
                            done_id  <= owner_q;
                            done_err <= ErrOk;
                            state_q  <= StDone;
                        end else if (rsp_dev_err) begin
                            done     <= 1'b1;
                            done_id  <= owner_q;
                            done_err <= ErrDevice;
                            state_q  <= StDone;
                        end else if (retry_q < RetryMax) begin
                            retry_q  <= retry_q + RetryW'(1);
                            state_q  <= StWaitTx;
                        end else begin
                            done     <= 1'b1;
                            done_id  <= owner_q;
                            done_err <= ErrRetries;
                            state_q  <= StDone;
                        end
                    end else if (timer_q == TimerLast) begin
                        done     <= 1'b1;
                        done_id  <= owner_q;
                        done_err <= ErrTimeout;
                        state_q  <= StDone;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end
                StDone: begin
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    retry_q <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// Self-checking bench for ps2_cmd_arbiter: directed scenarios plus randomized
// transactions checked against a response-sequence model of the arbiter.
module tb_ps2_cmd_arbiter;

    localparam int unsigned TO = 300;
    localparam int unsigned MR = 2;

    logic        clk_25MHz = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [7:0]  cmd0 = 8'h00;
    logic [7:0]  cmd1 = 8'h00;
    logic        gnt0;
    logic        gnt1;
    logic        done;
    logic        done_id;
    logic [1:0]  done_err;
    logic [10:0] tx_data;
    logic        write;
    logic        busy = 1'b0;
    logic [10:0] rx_data = 11'h7FF;
    logic        data_available = 1'b0;
    logic        err = 1'b0;

    ps2_cmd_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRY      (MR)
    ) dut (
        .clk_25MHz      (clk_25MHz),
        .reset          (reset),
        .req0           (req0),
        .req1           (req1),
        .cmd0           (cmd0),
        .cmd1           (cmd1),
        .gnt0           (gnt0),
        .gnt1           (gnt1),
        .done           (done),
        .done_id        (done_id),
        .done_err       (done_err),
        .tx_data        (tx_data),
        .write          (write),
        .busy           (busy),
        .rx_data        (rx_data),
        .data_available (data_available),
        .err            (err)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state, updated once per cycle by tick().
    int          cyc = 0;
    int          busy_until = 0;
    int          n_write = 0;
    int          n_done = 0;
    int          w_cyc = 0;
    int          d_cyc = 0;
    logic [10:0] w_data = '0;
    logic [1:0]  w_gnt = '0;
    logic [1:0]  d_gnt = '0;
    logic        d_id = 1'b0;
    logic [1:0]  d_err = '0;

    // Reference model state and the response plan for the next transaction.
    int m_last = 1;
    int q_kind[$];
    int q_dly[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25MHz);
        #1;
        cyc++;
        data_available = 1'b0;
        err = 1'b0;
        busy = (cyc < busy_until);
        if (write) begin
            n_write++;
            w_cyc  = cyc;
            w_data = tx_data;
            w_gnt  = {gnt1, gnt0};
        end
        if (done) begin
            n_done++;
            d_cyc = cyc;
            d_id  = done_id;
            d_err = done_err;
            d_gnt = {gnt1, gnt0};
        end
        if (gnt0 && gnt1) check_eq("gnt_exclusive", 32'(gnt0 & gnt1), 0);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b);
        int ones = $countones(b);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
    endfunction

    task automatic wait_write(input string tag, input int target);
        int k = 0;
        while (n_write < target && k < 2000) begin
            tick();
            k++;
        end
        if (n_write < target) check_eq({tag, "_write_seen"}, n_write, target);
    endtask

    task automatic wait_done(input string tag, input int target);
        int k = 0;
        while (n_done < target && k < 2000) begin
            tick();
            k++;
        end
        if (n_done < target) check_eq({tag, "_done_seen"}, n_done, target);
    endtask

    // kind: 0 FA, 1 FC, 2 FE, 3 other byte, 4 FA with bad parity, 5 FA with framing error
    task automatic drive_rsp(input int kind);
        logic [7:0] b;
        case (kind)
            1: b = 8'hFC;
            2: b = 8'hFE;
            3: begin
                do b = 8'($urandom); while (b == 8'hFA || b == 8'hFC || b == 8'hFE);
            end
            default: b = 8'hFA;
        endcase
        rx_data = frame(b);
        if (kind == 4) rx_data[9] = ~rx_data[9];
        err = (kind == 5);
        data_available = 1'b1;
    endtask

    task automatic model_grant(input bit r0, input bit r1, output int owner);
`ifdef PS2_ARB_ROUND_ROBIN_EN
        if (r0 && r1) owner = 1 - m_last;
        else owner = r0 ? 0 : 1;
`else
        owner = r0 ? 0 : 1;
`endif
        m_last = owner;
    endtask

    // Walk the planned responses: ACK/ERROR end it, anything else costs a retry.
    task automatic model_outcome(output int writes, output logic [1:0] code, output int used);
        writes = 1;
        code = 2'b11;
        used = 0;
        foreach (q_kind[i]) begin
            used = i + 1;
            if (q_kind[i] == 0) begin code = 2'b00; return; end
            if (q_kind[i] == 1) begin code = 2'b01; return; end
            if (writes - 1 < int'(MR)) writes++;
            else begin code = 2'b10; return; end
        end
    endtask

    task automatic run_txn(input string tag, input int who, input logic [7:0] cmd,
                           input int bhold);
        int owner, writes, used, start, base_w, base_d, r, exp_lat;
        logic [1:0] exp_err;
        model_grant(who == 0, who == 1, owner);
        model_outcome(writes, exp_err, used);
        if (who == 0) begin req0 = 1'b1; cmd0 = cmd; end
        else begin req1 = 1'b1; cmd1 = cmd; end
        start = cyc;
        busy_until = cyc + bhold;
        busy = (bhold > 0);
        base_w = n_write;
        base_d = n_done;
        r = cyc;
        exp_lat = (bhold + 1 > 3) ? bhold + 1 : 3;
        wait_write(tag, base_w + 1);
        check_eq({tag, "_latency"}, w_cyc - start, exp_lat);
        check_eq({tag, "_tx_data"}, w_data, frame(cmd));
        check_eq({tag, "_gnt_at_write"}, w_gnt, (owner == 1) ? 2'b10 : 2'b01);
        for (int i = 0; i < used; i++) begin
            repeat (q_dly[i]) tick();
            drive_rsp(q_kind[i]);
            r = cyc;
            if (i + 1 < writes) begin
                wait_write(tag, base_w + i + 2);
                check_eq({tag, "_retry_lat"}, w_cyc - r, 2);
                check_eq({tag, "_retry_tx"}, w_data, frame(cmd));
            end
        end
        wait_done(tag, base_d + 1);
        if (exp_err == 2'b11) check_eq({tag, "_timeout_at"}, d_cyc - w_cyc, TO + 1);
        else check_eq({tag, "_done_at"}, d_cyc - r, 1);
        check_eq({tag, "_done_id"}, d_id, owner);
        check_eq({tag, "_done_err"}, d_err, exp_err);
        check_eq({tag, "_gnt_at_done"}, d_gnt, (owner == 1) ? 2'b10 : 2'b01);
        check_eq({tag, "_writes"}, n_write - base_w, writes);
        tick();
        check_eq({tag, "_gnt_cleared"}, {gnt1, gnt0}, 0);
        check_eq({tag, "_done_pulse"}, done, 0);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check_eq({tag, "_err_hold"}, done_err, exp_err);
    endtask

    task automatic plan(input int k0, input int d0, input int n);
        q_kind = {};
        q_dly = {};
        for (int i = 0; i < n; i++) begin
            q_kind.push_back(k0);
            q_dly.push_back(d0);
        end
    endtask

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int owner, base_w, base_d, who, nrsp, bh;

        repeat (3) tick();
        check_eq("rst_gnt", {gnt1, gnt0}, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_write", write, 0);
        check_eq("rst_tx_data", tx_data, 11'h7FF);
        check_eq("rst_done_id", done_id, 0);
        check_eq("rst_done_err", done_err, 0);
        reset = 1'b0;
        tick();

        // Basic ACK, 10 cycles after the write.
        plan(0, 10, 1);
        run_txn("t1", 0, 8'hF4, 0);
        check_eq("t1_frame_literal", w_data, 11'b10111101000);

        // RESEND twice then ACK; RESEND three times exhausts retries.
        plan(2, 4, 2);
        q_kind.push_back(0);
        q_dly.push_back(5);
        run_txn("t2a", 1, 8'hF3, 0);
        plan(2, 3, 3);
        run_txn("t2b", 1, 8'hF3, 0);

        // No response -> timeout; device ERROR.
        plan(0, 1, 0);
        run_txn("t3a", 0, 8'hFF, 0);
        plan(1, 6, 1);
        run_txn("t3b", 0, 8'hFF, 0);

        // Long busy, then a corrupt-parity ACK is retried.
        plan(4, 7, 1);
        q_kind.push_back(0);
        q_dly.push_back(2);
        run_txn("t4", 0, 8'hE8, 50);

        // ACK arriving on the exact cycle the timer expires still counts.
        plan(0, TO, 1);
        run_txn("t4_edge", 1, 8'h0A, 0);

        for (int t = 0; t < 24; t++) begin
            who = int'($urandom_range(0, 1));
            bh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
            nrsp = int'($urandom_range(0, 4));
            q_kind = {};
            q_dly = {};
            for (int i = 0; i < nrsp; i++) begin
                q_kind.push_back(int'($urandom_range(0, 5)));
                q_dly.push_back(int'($urandom_range(1, 12)));
            end
            run_txn("rnd", who, 8'($urandom), bh);
        end

        // Both requesters held high across four transactions.
        req0 = 1'b1;
        req1 = 1'b1;
        cmd0 = 8'h11;
        cmd1 = 8'h22;
        base_w = n_write;
        base_d = n_done;
        for (int k = 0; k < 4; k++) begin
            model_grant(1'b1, 1'b1, owner);
            wait_write("t5", base_w + k + 1);
            check_eq("t5_tx_data", w_data, frame((owner == 1) ? cmd1 : cmd0));
            repeat (3) tick();
            drive_rsp(0);
            wait_done("t5", base_d + k + 1);
            check_eq("t5_owner", d_id, owner);
            check_eq("t5_err", d_err, 0);
        end
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        base_w = n_write;
        repeat (10) tick();
        check_eq("t5_no_extra_write", n_write - base_w, 0);

        // Reset while waiting for the response aborts silently.
        req0 = 1'b1;
        cmd0 = 8'hAB;
        base_w = n_write;
        base_d = n_done;
        wait_write("t6", base_w + 1);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_eq("t6_rst_gnt", {gnt1, gnt0}, 0);
        check_eq("t6_rst_done", done, 0);
        check_eq("t6_rst_write", write, 0);
        check_eq("t6_rst_tx_data", tx_data, 11'h7FF);
        check_eq("t6_rst_done_id", done_id, 0);
        check_eq("t6_rst_done_err", done_err, 0);
        reset = 1'b0;
        req0 = 1'b0;
        m_last = 1;
        drive_rsp(0);
        repeat (5) tick();
        check_eq("t6_no_done", n_done - base_d, 0);
        plan(0, 3, 1);
        run_txn("t6_after", 1, 8'h5A, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
